jam_cost_table: RTL and testbench

//   Cost-table responder on the worker/job query interface of the job-assignment engine.

---
 rtl/jam_cost_table.sv | 102 ++++++++++
 tb/tb_jam_cost_table.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/jam_cost_table.sv
// jam_cost_table: 8x8 cost matrix for the job-assignment engine.
// Streaming load fills the table row-major; queries return table[W][J]
// one cycle later. Also tracks a load checksum, a query count and a
// sticky load-protocol error flag.
module jam_cost_table #(
    parameter int N_IDX  = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    input  logic              Req,
    output logic [COST_W-1:0] Cost,
    input  logic              LoadStart,
    input  logic              LoadValid,
    input  logic [COST_W-1:0] LoadData,
    output logic              Ready,
    output logic [12:0]       LoadSum,
    output logic [15:0]       QueryCount,
    output logic              LoadErr
);

    localparam int ENTRIES = N_IDX * N_IDX;
    localparam int PTR_W   = 2 * IDX_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [COST_W-1:0] mem [ENTRIES];
    logic              wr_en;
    logic [PTR_W-1:0]  rd_idx;

    // A same-cycle LoadStart restarts the load, so its data beat is dropped.
    assign wr_en  = (state == S_LOAD) && LoadValid && !LoadStart;
    // N_IDX is a power of two, so row-major W*N_IDX+J is a plain concatenation.
    assign rd_idx = {W, J};

    // Table storage: written only by accepted load beats, never reset.
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[ptr] <= LoadData;
    end

    // Load FSM: pointer, checksum, Ready and the sticky error flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_EMPTY;
            ptr     <= '0;
            LoadSum <= '0;
            Ready   <= 1'b0;
            LoadErr <= 1'b0;
        end else if (LoadStart) begin
            state   <= S_LOAD;
            ptr     <= '0;
            LoadSum <= '0;
            Ready   <= 1'b0;
            LoadErr <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (LoadValid) begin
                        LoadSum <= LoadSum + 13'(LoadData);
                        ptr     <= ptr + 1'b1;   // wraps to 0 after the last entry
                        if (ptr == LAST_PTR) begin
                            state <= S_READY;
                            Ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (LoadValid)
                        LoadErr <= 1'b1;
                end
            endcase
        end
    end

    // Query path: one result per cycle, zero unless the table is complete.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            Cost <= '0;
        else
            Cost <= (state == S_READY) ? mem[rd_idx] : '0;
    end

    // Saturating count of Req cycles seen while the table is ready.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            QueryCount <= '0;
        else if (Req && (state == S_READY) && (QueryCount != 16'hFFFF))
            QueryCount <= QueryCount + 16'd1;
    end

endmodule

// File: tb/tb_jam_cost_table.sv
// tb_jam_cost_table: directed checks of load, query, reload, error and reset behaviour.
module tb_jam_cost_table;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  W = '0;
    logic [2:0]  J = '0;
    logic        Req = 1'b0;
    logic [6:0]  Cost;
    logic        LoadStart = 1'b0;
    logic        LoadValid = 1'b0;
    logic [6:0]  LoadData = '0;
    logic        Ready;
    logic [12:0] LoadSum;
    logic [15:0] QueryCount;
    logic        LoadErr;

    int n_chk = 0;
    int n_err = 0;
    int tbl [64];
    int sum;

    jam_cost_table dut (
        .CLK(CLK), .RST(RST), .W(W), .J(J), .Req(Req), .Cost(Cost),
        .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData),
        .Ready(Ready), .LoadSum(LoadSum), .QueryCount(QueryCount), .LoadErr(LoadErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int d);
        LoadValid = 1'b1;
        LoadData  = 7'(d);
        step();
        LoadValid = 1'b0;
    endtask

    task automatic start();
        LoadStart = 1'b1;
        step();
        LoadStart = 1'b0;
    endtask

    initial begin
        // 1: reset state, Cost stays 0 while W/J toggle, LoadValid in EMPTY flags error
        step();
        RST = 1'b0;
        chk("rst_cost", Cost, 0);
        chk("rst_ready", Ready, 0);
        chk("rst_sum", LoadSum, 0);
        chk("rst_qcnt", QueryCount, 0);
        chk("rst_err", LoadErr, 0);
        for (int i = 0; i < 4; i++) begin
            W = 3'(i + 1); J = 3'(7 - i);
            step();
            chk("empty_cost", Cost, 0);
        end
        push(5);
        chk("empty_err", LoadErr, 1);

        // 2: full load of idx%128, Ready one cycle after entry 64
        start();
        chk("start_err_clr", LoadErr, 0);
        for (int i = 0; i < 64; i++) begin
            if (i == 63) chk("ready_before_last", Ready, 0);
            tbl[i] = i % 128;
            push(tbl[i]);
        end
        chk("ready_after_last", Ready, 1);
        chk("sum_ramp", LoadSum, 2016);
        W = 3'd3; J = 3'd5;
        step();
        chk("cost_3_5", Cost, 29);

        // 3: back-to-back sweep of all 64 pairs with Req high
        Req = 1'b1;
        for (int k = 0; k < 64; k++) begin
            W = 3'(k / 8); J = 3'(k % 8);
            step();
            chk("sweep_cost", Cost, tbl[k]);
        end
        Req = 1'b0;
        step();
        chk("qcnt_64", QueryCount, 64);

        // 4: partial load, restart, full load of 7'h7F
        W = 3'd7; J = 3'd7;
        start();
        for (int i = 0; i < 40; i++) push(1);
        chk("partial_ready", Ready, 0);
        chk("partial_cost", Cost, 0);
        chk("partial_sum", LoadSum, 40);
        start();
        chk("restart_sum", LoadSum, 0);
        for (int i = 0; i < 64; i++) begin
            if (i == 63) chk("reload_ready_early", Ready, 0);
            tbl[i] = 127;
            push(127);
        end
        chk("reload_ready", Ready, 1);
        chk("sum_max", LoadSum, 8128);
        W = 3'd2; J = 3'd6;
        step();
        chk("cost_max", Cost, 127);
        chk("qcnt_kept", QueryCount, 64);

        // 5: LoadValid in READY sets sticky error, table and sum untouched
        push(9);
        step();
        chk("ready_err", LoadErr, 1);
        chk("ready_err_sum", LoadSum, 8128);
        chk("ready_err_cost", Cost, 127);
        chk("ready_err_rdy", Ready, 1);
        start();
        chk("err_cleared", LoadErr, 0);
        chk("reload_not_ready", Ready, 0);

        // 6: async reset mid-load, then LoadStart+LoadValid drops the first beat
        for (int i = 0; i < 30; i++) push(2);
        chk("mid_sum", LoadSum, 60);
        RST = 1'b1;
        #1;
        chk("async_ready", Ready, 0);
        chk("async_sum", LoadSum, 0);
        chk("async_cost", Cost, 0);
        chk("async_qcnt", QueryCount, 0);
        step();
        RST = 1'b0;
        LoadStart = 1'b1; LoadValid = 1'b1; LoadData = 7'd100;
        step();
        LoadStart = 1'b0; LoadValid = 1'b0;
        chk("drop_sum", LoadSum, 0);
        sum = 0;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) chk("drop_ready_early", Ready, 0);
            tbl[i] = i % 7;
            sum += tbl[i];
            push(tbl[i]);
        end
        chk("drop_ready", Ready, 1);
        chk("drop_sum_full", LoadSum, sum);
        W = 3'd0; J = 3'd0;
        step();
        chk("drop_cost_0", Cost, tbl[0]);
        W = 3'd1; J = 3'd2;
        step();
        chk("drop_cost_10", Cost, tbl[10]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
